// File: rtl/fp_pkg.sv
// Shared floating-point constants, flag positions and the default-format
// unpacked operand view used by the pipelined adder.
package fp_pkg;

  // Default format is IEEE single precision.
  localparam int unsigned EXP_W_DEF = 8;
  localparam int unsigned MAN_W_DEF = 23;
  localparam int unsigned W_DEF     = 1 + EXP_W_DEF + MAN_W_DEF;

  localparam int unsigned              BIAS    = (1 << (EXP_W_DEF - 1)) - 1;
  localparam logic [EXP_W_DEF-1:0]     EXP_MAX = '1;
  localparam logic [W_DEF-1:0]         QNAN    = {1'b0, EXP_MAX, 1'b1, {(MAN_W_DEF-1){1'b0}}};

  // Result flag vector {invalid, overflow, inexact}.
  localparam int unsigned FLAG_W        = 3;
  localparam int unsigned FLAG_INEXACT  = 0;
  localparam int unsigned FLAG_OVERFLOW = 1;
  localparam int unsigned FLAG_INVALID  = 2;

  // Unpacked operand in the default format; man_ext carries the hidden bit.
  typedef struct packed {
    logic                 sign;
    logic [EXP_W_DEF-1:0] exp;
    logic [MAN_W_DEF:0]   man_ext;
    logic                 is_zero;
    logic                 is_inf;
    logic                 is_nan;
  } fp_op_t;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter (combinational).
//   din      : value to scan, MSB first
//   cnt      : number of zeros above the most significant one
//   all_zero : din has no bit set (cnt is then 0 and meaningless)
module fp_lzc #(
  parameter int unsigned WIDTH = 28,
  localparam int unsigned CW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CW-1:0]    cnt,
  output logic             all_zero
);

  // Scan upwards so the highest set bit wins.
  always_comb begin
    cnt      = '0;
    all_zero = (din == '0);
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) cnt = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor, flush-to-zero,
// round to nearest even, valid/ready handshake with global stall.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : operand handshake
//   in_sub, in_a, in_b   : A+B or A-B
//   out_valid/out_ready  : result handshake
//   out_sum, out_flags   : rounded result and {invalid, overflow, inexact}
module fp_add_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF,
  localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sub,
  input  logic [W-1:0]      in_a,
  input  logic [W-1:0]      in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_sum,
  output logic [FLAG_W-1:0] out_flags
);

  localparam int unsigned FW  = MAN_W + 4;   // {hidden, man, guard, round, sticky}
  localparam int unsigned SW  = MAN_W + 5;   // aligned sum including carry-out
  localparam int unsigned XW  = EXP_W + 2;   // signed exponent working width
  localparam int unsigned LZW = $clog2(SW);

  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic [W-1:0]         QNAN_W   = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
  localparam logic signed [XW-1:0] EXP_OVF  = XW'((1 << EXP_W) - 1);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   man_ext;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } op_t;

  function automatic op_t unpack(input logic [W-1:0] w, input logic neg);
    op_t o;
    o.sign    = w[W-1] ^ neg;
    o.exp     = w[W-2 -: EXP_W];
    o.man_ext = {1'b1, w[MAN_W-1:0]};
    o.is_zero = (o.exp == '0);
    o.is_inf  = (o.exp == EXP_ONES) && (w[MAN_W-1:0] == '0);
    o.is_nan  = (o.exp == EXP_ONES) && (w[MAN_W-1:0] != '0);
    return o;
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- stage 1: unpack, specials, swap and align ----------------
  op_t              op_a, op_b;
  logic             a_ge, sign_x, sign_y;
  logic [EXP_W-1:0] exp_x, exp_y, d;
  logic [MAN_W:0]   man_x, man_y;
  logic [FW-1:0]    y_full, y_al;
  logic             sp_hit;
  logic [W-1:0]     sp_word;
  logic [FLAG_W-1:0] sp_flags;

  assign op_a = unpack(in_a, 1'b0);
  assign op_b = unpack(in_b, in_sub);

  always_comb begin
    a_ge   = {op_a.exp, op_a.man_ext} >= {op_b.exp, op_b.man_ext};
    sign_x = a_ge ? op_a.sign    : op_b.sign;
    sign_y = a_ge ? op_b.sign    : op_a.sign;
    exp_x  = a_ge ? op_a.exp     : op_b.exp;
    exp_y  = a_ge ? op_b.exp     : op_a.exp;
    man_x  = a_ge ? op_a.man_ext : op_b.man_ext;
    man_y  = a_ge ? op_b.man_ext : op_a.man_ext;
    d      = exp_x - exp_y;
    y_full = {man_y, 3'b000};
    // Far-shifted Y survives only as sticky.
    if (d > EXP_W'(MAN_W + 2)) y_al = FW'(1);
    else                       y_al = (y_full >> d) | FW'(|(y_full & ~({FW{1'b1}} << d)));
  end

  // Results that bypass the arithmetic path.
  always_comb begin
    sp_hit   = 1'b1;
    sp_word  = '0;
    sp_flags = '0;
    if (op_a.is_nan || op_b.is_nan) begin
      sp_word = QNAN_W;
    end else if (op_a.is_inf && op_b.is_inf) begin
      if (op_a.sign != op_b.sign) begin
        sp_word                = QNAN_W;
        sp_flags[FLAG_INVALID] = 1'b1;
      end else begin
        sp_word = {op_a.sign, EXP_ONES, MAN_W'(0)};
      end
    end else if (op_a.is_inf) begin
      sp_word = {op_a.sign, EXP_ONES, MAN_W'(0)};
    end else if (op_b.is_inf) begin
      sp_word = {op_b.sign, EXP_ONES, MAN_W'(0)};
    end else if (op_a.is_zero && op_b.is_zero) begin
      sp_word = {op_a.sign & op_b.sign, (W-1)'(0)};
    end else if (op_a.is_zero) begin
      sp_word = {op_b.sign, in_b[W-2:0]};
    end else if (op_b.is_zero) begin
      sp_word = {op_a.sign, in_a[W-2:0]};
    end else begin
      sp_hit = 1'b0;
    end
  end

  logic              s1_sub, s1_sign, s1_sp;
  logic [EXP_W-1:0]  s1_exp;
  logic [FW-1:0]     s1_x, s1_y;
  logic [W-1:0]      s1_sp_word;
  logic [FLAG_W-1:0] s1_sp_flags;

  // ---------------- stage 2: magnitude add/subtract ----------------
  logic              s2_sign, s2_sp;
  logic [EXP_W-1:0]  s2_exp;
  logic [SW-1:0]     s2_sum;
  logic [W-1:0]      s2_sp_word;
  logic [FLAG_W-1:0] s2_sp_flags;

  // Datapath registers need no reset; validity lives in the control flops.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sub      <= sign_x ^ sign_y;
      s1_sign     <= sign_x;
      s1_exp      <= exp_x;
      s1_x        <= {man_x, 3'b000};
      s1_y        <= y_al;
      s1_sp       <= sp_hit;
      s1_sp_word  <= sp_word;
      s1_sp_flags <= sp_flags;
      s2_sign     <= s1_sign;
      s2_exp      <= s1_exp;
      s2_sum      <= s1_sub ? ({1'b0, s1_x} - {1'b0, s1_y}) : ({1'b0, s1_x} + {1'b0, s1_y});
      s2_sp       <= s1_sp;
      s2_sp_word  <= s1_sp_word;
      s2_sp_flags <= s1_sp_flags;
    end
  end

  // ---------------- stage 3: normalise and round ----------------
  logic [LZW-1:0]        lz, shift;
  logic                  lz_zero, carry, zero_res, uf, up, inexact;
  logic signed [XW-1:0]  exp_s, shift_s, e_n, e_r;
  logic [FW-1:0]         n;
  logic [MAN_W+1:0]      man_r;
  logic [MAN_W-1:0]      frac;
  logic [W-1:0]          res_word;
  logic [FLAG_W-1:0]     res_flags;
  logic                  unused_hidden;

  fp_lzc #(.WIDTH(SW)) u_lzc (
    .din      (s2_sum),
    .cnt      (lz),
    .all_zero (lz_zero)
  );

  assign unused_hidden = man_r[MAN_W];

  always_comb begin
    carry    = s2_sum[SW-1];
    shift    = lz - LZW'(1);
    exp_s    = $signed({2'b00, s2_exp});
    shift_s  = $signed({{(XW-LZW){1'b0}}, shift});
    n        = '0;
    e_n      = exp_s;
    zero_res = 1'b0;
    uf       = 1'b0;
    if (carry) begin
      n   = {s2_sum[SW-1:2], |s2_sum[1:0]};
      e_n = exp_s + EXP_ONE;
    end else if (lz_zero) begin
      zero_res = 1'b1;
    end else if (shift_s > exp_s - EXP_ONE) begin
      uf = 1'b1;     // would need an exponent below 1: flush
    end else begin
      n   = s2_sum[FW-1:0] << shift;
      e_n = exp_s - shift_s;
    end

    up      = n[2] & (n[1] | n[0] | n[3]);
    inexact = |n[2:0];
    man_r   = {1'b0, n[FW-1:3]} + (MAN_W+2)'(up);
    e_r     = e_n;
    frac    = man_r[MAN_W-1:0];
    if (man_r[MAN_W+1]) begin
      e_r  = e_n + EXP_ONE;
      frac = '0;
    end

    res_word                = {s2_sign, e_r[EXP_W-1:0], frac};
    res_flags               = '0;
    res_flags[FLAG_INEXACT] = inexact;
    if (s2_sp) begin
      res_word  = s2_sp_word;
      res_flags = s2_sp_flags;
    end else if (zero_res) begin
      res_word  = '0;               // exact cancellation is +0
      res_flags = '0;
    end else if (uf) begin
      res_word                = {s2_sign, (W-1)'(0)};
      res_flags               = '0;
      res_flags[FLAG_INEXACT] = 1'b1;
    end else if (e_r >= EXP_OVF) begin
      res_word                 = {s2_sign, EXP_ONES, MAN_W'(0)};
      res_flags                = '0;
      res_flags[FLAG_OVERFLOW] = 1'b1;
      res_flags[FLAG_INEXACT]  = 1'b1;
    end
  end

  // Valids and the output word; all hold while the consumer stalls.
  logic s1_valid, s2_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_flags <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_sum   <= res_word;
        out_flags <= res_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe: FP32 instance with handshake, stall and
// reset scenarios, plus an FP16 instance for the parameterised build.
module tb_fp_add_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_sum;
  logic [2:0]  out_flags;

  logic        h_in_valid, h_in_ready, h_in_sub, h_out_valid, h_out_ready;
  logic [15:0] h_in_a, h_in_b, h_out_sum;
  logic [2:0]  h_out_flags;

  fp_add_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_flags(out_flags)
  );

  fp_add_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .in_sub(h_in_sub),
    .in_a(h_in_a), .in_b(h_in_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .out_sum(h_out_sum), .out_flags(h_out_flags)
  );

  typedef struct {
    logic [31:0] sum;
    logic [2:0]  flags;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0, n_out = 0;
  int   stall_lo = 1, stall_hi = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) out_ready = !(cyc >= stall_lo && cyc <= stall_hi);

  // Output monitor: pops the scoreboard on each accepted result.
  logic [34:0] held;
  bit          holding = 0;
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      holding = 0;
    end else begin
      if (holding) chk("stall_hold", {out_valid, out_flags, out_sum}, {1'b1, held});
      holding = 0;
      if (out_valid && !out_ready) begin
        chk("in_ready_stall", in_ready, 1'b0);
        held    = {out_flags, out_sum};
        holding = 1;
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("sum", out_sum, e.sum);
          chk("flags", out_flags, e.flags);
          if (e.lat) chk("latency", cyc - e.cyc, 3);
          n_out++;
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [31:0] es, input logic [2:0] ef, input bit lat);
    exp_t e;
    int   budget = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = s;
    #1;
    while (!in_ready && budget < 50) begin
      @(negedge clk); #1; budget++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1'b1);
    end else begin
      e.sum = es; e.flags = ef; e.cyc = cyc; e.lat = lat;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    #2;
    chk("drain", sb_q.size(), 0);
  endtask

  task automatic hsend(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] es, input logic [2:0] ef);
    @(negedge clk);
    h_in_valid = 1'b1; h_in_a = a; h_in_b = b; h_in_sub = 1'b0;
    @(negedge clk);
    h_in_valid = 1'b0;
    #1;
    for (int i = 0; i < 10 && !h_out_valid; i++) begin
      @(negedge clk); #1;
    end
    chk("h_valid", h_out_valid, 1'b1);
    chk("h_sum", h_out_sum, es);
    chk("h_flags", h_out_flags, ef);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    int base, out0;
    rst = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_a = '0; in_b = '0;
    h_in_valid = 1'b0; h_in_sub = 1'b0; h_in_a = '0; h_in_b = '0; h_out_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum", out_sum, 32'h0);
    chk("rst_out_flags", out_flags, 3'b000);
    chk("rst_in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single op with latency check.
    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 1'b1);
    idle(); drain();

    // Directed cases, back to back.
    send(32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 3'b000, 1'b0);
    send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, 1'b0);
    send(32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, 3'b000, 1'b0);
    send(32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 3'b001, 1'b0);
    send(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001, 1'b0);
    send(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b001, 1'b0);
    send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 1'b0);
    send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, 1'b0);
    send(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000, 1'b0);
    send(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100, 1'b0);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011, 1'b0);
    send(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000, 1'b0);
    send(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000, 1'b0);
    send(32'hBF800000, 32'h40000000, 1'b0, 32'h3F800000, 3'b000, 1'b0);
    idle(); drain();

    // Six-op stream with the consumer stalled for five cycles.
    @(negedge clk);
    base = cyc; out0 = n_out;
    stall_lo = base + 4; stall_hi = base + 8;
    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 1'b0);
    send(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 3'b000, 1'b0);
    send(32'h40A00000, 32'h3F800000, 1'b0, 32'h40C00000, 3'b000, 1'b0);
    send(32'hBF800000, 32'h40000000, 1'b0, 32'h3F800000, 3'b000, 1'b0);
    send(32'h41200000, 32'h40A00000, 1'b1, 32'h40A00000, 3'b000, 1'b0);
    send(32'hC0000000, 32'hC0000000, 1'b0, 32'hC0800000, 3'b000, 1'b0);
    idle(); drain();
    chk("stream_count", n_out - out0, 6);

    // Asynchronous reset with three ops in flight.
    send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 3'b000, 1'b0);
    send(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 3'b000, 1'b0);
    send(32'h40A00000, 32'h40A00000, 1'b0, 32'h41200000, 3'b000, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 1'b0);
    chk("rst_async_sum", out_sum, 32'h0);
    chk("rst_async_in_ready", in_ready, 1'b1);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("no_stale", out_valid, 1'b0);
    end
    send(32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 3'b000, 1'b1);
    idle(); drain();

    // Half-precision build.
    hsend(16'h3C00, 16'h3C00, 16'h4000, 3'b000);
    hsend(16'h7BFF, 16'h7BFF, 16'h7C00, 3'b011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
- Parametrised, pipelined IEEE-754 style floating-point adder/subtractor; successor to the combinational single-precision adder.
- Handles unlike-sign addition with full left normalisation and round-to-nearest-even.
- Three-stage pipeline with valid/ready handshake, so it can sit directly in the accumulation datapath of the processing array.
- Default configuration is FP32; the same RTL builds FP16/BF16 by parameter.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa (fraction) width, hidden bit excluded.
- Derived, not a parameter: W = 1+EXP_W+MAN_W, total word width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- in_sub  in  1  0: A+B, 1: A-B (inverts sign of B).
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  W  rounded result.
- out_flags  out  3  {invalid, overflow, inexact} for the result on out_sum.

Behaviour:
- Reset: all stage valids, out_valid, out_sum and out_flags are 0 immediately on rst and held until rst falls. In-flight operations are discarded. in_ready = 1 while rst is asserted.
- Handshake:
  - Transfer occurs when valid && ready on each side.
  - Pipeline advance enable: adv = !out_valid || out_ready. in_ready = adv (global stall, no skid buffer).
  - When adv = 0, all stage registers hold; out_sum and out_flags stay stable while out_valid = 1.
- Latency: exactly 3 cycles from input transfer to out_valid with no stall. Throughput is 1 per cycle.
- Stage 1, unpack/align:
  - Swap operands so |X| >= |Y|, comparing {exp,man}.
  - Effective operation = sign(X) xor sign(Y)', where sign(Y)' includes the in_sub inversion.
  - d = eX - eY. Shift {1,mY} right by d into a field with 3 extra bits (guard, round, sticky); sticky ORs all shifted-out bits.
  - If d > MAN_W+2, Y collapses to sticky only.
- Stage 2, add/sub: MAN_W+5-bit add or subtract of aligned mantissas. Result is non-negative by construction of the swap.
- Stage 3, normalise/round:
  - On carry-out, shift right 1 and increment the exponent.
  - Otherwise, left shift by the leading-zero count (fp_lzc), limited so the exponent does not go below 1. A limit hit means an underflow result, which is flushed to signed zero.
  - Round to nearest, ties to even. A round carry renormalises.
  - inexact = any of guard, round or sticky set.
- Exact zero result from unlike signs is +0. (-0)+(-0) gives -0.
- Special cases, decided in stage 1 and carried as a bypass:
  - Denormal inputs (exp = 0) are treated as signed zero (flush-to-zero).
  - NaN input gives canonical quiet NaN {0, all-ones exp, 1 followed by zeros}, invalid = 0.
  - Inf - Inf gives canonical NaN, invalid = 1.
  - Inf ± finite gives that Inf.
  - Zero + X gives X exactly.
- Overflow: exponent reaching all-ones after rounding gives signed Inf, overflow = 1, inexact = 1.
- Widths: exponent arithmetic is EXP_W+2 bits signed internally to catch overflow and underflow before saturation.

Decomposition:
- Package fp_pkg:
  - Constants: EXP_W/MAN_W defaults, BIAS = 2^(EXP_W-1)-1, EXP_MAX, canonical QNAN.
  - Typedef of the unpacked operand struct {sign, exp, man_ext, is_zero, is_inf, is_nan}.
  - Flag bit indices.
- Sub-module fp_lzc: parametrised leading-zero counter, combinational, width MAN_W+5, output $clog2 width plus all-zero flag.

Test Plan:
- 1.0 + 1.0 → out_sum 0x40000000, flags 0, out_valid exactly 3 cycles after input transfer. 1.5 - 1.0 (0x3FC00000, 0x3F800000, in_sub = 1) → 0x3F000000.
- Rounding: 0x3F800000 + 0x33800000 (tie) → 0x3F800000, inexact = 1. 0x3F800000 + 0x34000000 → 0x3F800001, inexact = 0. 0x3F800000 + 0x30800000 → 0x3F800000, inexact = 1.
- Cancellation and zero: 0x3F800000 - 0x3F800000 → 0x00000000. 0x80000000 + 0x80000000 → 0x80000000. Denormal 0x00000001 + 0x3F800000 → 0x3F800000.
- Specials: 0x7F800000 - 0x7F800000 (in_sub = 1) → 0x7FC00000, invalid = 1. 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow = 1.
- Backpressure: stream 6 back-to-back pairs with out_ready = 0 for cycles 4-8.
  - in_ready drops while out_valid is held.
  - out_sum stays stable during the stall.
  - All 6 results emerge in order with no loss or duplication.
- Reset mid-stream: assert rst asynchronously with 3 ops in flight → out_valid = 0 and out_sum = 0 within the same cycle. After release, the first new op's result appears 3 cycles after acceptance; no stale result is emitted.
- Parameter build EXP_W = 5, MAN_W = 10 (FP16): 0x3C00 + 0x3C00 → 0x4000. 0x7BFF + 0x7BFF → 0x7C00, overflow = 1.
